// File: rtl/stat_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module : stat_update_arbiter
// Round-robin sharing of one vec_counter among N_REQ sources, plus RAM clear.
// Rev    : 1.0
// ============================================================================
module stat_update_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 4,
    parameter int VAL_W   = 32,
    parameter int VEC_NUM = 16,
    parameter int HOLDOFF = 4,
    parameter int DRAIN   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ*IDX_W*VEC_NUM-1:0] req_index,
    input  logic [N_REQ*VAL_W*VEC_NUM-1:0] req_value,
    output logic [N_REQ-1:0]               ack,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic [3:0]                     base_addr,
    output logic [IDX_W*VEC_NUM-1:0]       vec_index_out,
    output logic [VAL_W*VEC_NUM-1:0]       vec_value_out,
    input  logic [IDX_W*VEC_NUM-1:0]       clr_out_in,
    output logic                           clr_in
);

    localparam int IW    = IDX_W * VEC_NUM;
    localparam int VW    = VAL_W * VEC_NUM;
    localparam int HO_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam int CNT_W = 10;

    localparam logic [CNT_W-1:0] C_DRAIN_LAST = CNT_W'(DRAIN - 1);
    localparam logic [CNT_W-1:0] C_CLEAR_LAST = '1;
    localparam logic [HO_W-1:0]  C_HOLDOFF    = HO_W'(HOLDOFF);
    localparam logic [3:0]       C_LAST_REQ   = 4'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BURST     = 2'd1,
        ST_CLR_DRAIN = 2'd2,
        ST_CLEAR     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IW-1:0]     r_pend;
    logic [3:0]        r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_clr_pend;

    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_load_hold;
    logic              w_any;
    logic [3:0]        w_sel;
    logic [IW-1:0]     w_sel_idx;
    logic [VW-1:0]     w_sel_val;
    logic              w_clr_go;
    logic              w_do_grant;
    logic              w_burst_done;

    // Masking with the counter's clear strobe keeps a bit from being counted twice.
    assign vec_index_out = r_pend & ~clr_out_in;
    assign clr_in        = (r_state == ST_CLEAR);
    assign w_clr_go      = clr_req | r_clr_pend;
    assign w_burst_done  = (r_state == ST_BURST) && (vec_index_out == '0);

    // Lowest eligible at or above the pointer wins, else lowest eligible overall.
    always_comb begin
        w_any     = 1'b0;
        w_sel     = '0;
        w_sel_idx = '0;
        w_sel_val = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any = 1'b1;
                w_sel = 4'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_elig[i] && (4'(i) >= r_ptr)) begin
                w_sel = 4'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == 4'(i)) begin
                w_sel_idx = req_index[i*IW +: IW];
                w_sel_val = req_value[i*VW +: VW];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_do_grant   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clr_go) begin
                    w_state_next = ST_CLR_DRAIN;
                end else if (w_any) begin
                    w_do_grant = 1'b1;
                    if (w_sel_idx != '0) begin
                        w_state_next = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (vec_index_out == '0) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CLR_DRAIN: begin
                if (r_cnt == C_DRAIN_LAST) begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == C_CLEAR_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend        <= '0;
            vec_value_out <= '0;
            base_addr     <= '0;
            r_ptr         <= '0;
            ack           <= '0;
            r_cnt         <= '0;
            r_clr_pend    <= 1'b0;
            clr_busy      <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                ack[i] <= w_do_grant && (w_sel == 4'(i));
            end

            if (r_state == ST_BURST) begin
                r_pend <= r_pend & ~clr_out_in;
            end
            if (w_do_grant) begin
                r_pend        <= w_sel_idx;
                vec_value_out <= w_sel_val;
                base_addr     <= w_sel;
                r_ptr         <= (w_sel == C_LAST_REQ) ? 4'd0 : (w_sel + 4'd1);
            end

            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_CLR_DRAIN) || (r_state == ST_CLEAR)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == ST_CLEAR) && (w_state_next == ST_IDLE)) begin
                r_clr_pend <= 1'b0;
                clr_busy   <= 1'b0;
            end else if ((r_state == ST_BURST) && clr_req) begin
                r_clr_pend <= 1'b1;
                clr_busy   <= 1'b1;
            end else if ((r_state == ST_IDLE) && w_clr_go) begin
                clr_busy   <= 1'b1;
            end
        end
    end

    // Holdoff starts at burst exit, or at the grant itself for an all-zero index.
    for (genvar g = 0; g < N_REQ; g++) begin : g_hold
        logic [HO_W-1:0] r_hold;

        assign w_load_hold[g] = (w_burst_done && (base_addr == 4'(g))) ||
                                (w_do_grant && (w_sel == 4'(g)) && (w_sel_idx == '0));
        assign w_elig[g]      = req[g] && (r_hold == '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hold <= '0;
            end else if (w_load_hold[g]) begin
                r_hold <= C_HOLDOFF;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stat_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_stat_update_arbiter
// Directed bench for stat_update_arbiter with a behavioural vec_counter strobe.
// Rev    : 1.0
// ============================================================================
module tb_stat_update_arbiter;

    localparam int N  = 4;
    localparam int IW = 64;
    localparam int VW = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*IW-1:0]   req_index = '0;
    logic [N*VW-1:0]   req_value = '0;
    logic [N-1:0]      ack;
    logic              clr_req = 1'b0;
    logic              clr_busy;
    logic [3:0]        base_addr;
    logic [IW-1:0]     vec_index_out;
    logic [VW-1:0]     vec_value_out;
    logic [IW-1:0]     clr_out_in;
    logic              clr_in;

    int total = 0;
    int bad   = 0;

    stat_update_arbiter #(
        .N_REQ(N), .IDX_W(4), .VAL_W(32), .VEC_NUM(16), .HOLDOFF(4), .DRAIN(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_index(req_index), .req_value(req_value),
        .ack(ack), .clr_req(clr_req), .clr_busy(clr_busy), .base_addr(base_addr),
        .vec_index_out(vec_index_out), .vec_value_out(vec_value_out),
        .clr_out_in(clr_out_in), .clr_in(clr_in)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] hb(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int b = 0; b < IW; b++) if (v[b]) r = 64'd1 << b;
        return r;
    endfunction

    // vec_counter stand-in: strobes the highest pending bit one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) clr_out_in <= '0;
        else     clr_out_in <= hb(vec_index_out);
    end

    function automatic logic [VW-1:0] mkval(input int i);
        logic [VW-1:0] v;
        for (int e = 0; e < 16; e++) v[e*32 +: 32] = 32'h5A00_0000 + 32'(e * 16 + i);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [IW-1:0] idx);
        req_index[i*IW +: IW] = idx;
        req_value[i*VW +: VW] = mkval(i);
        req[i] = 1'b1;
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] who, output int dt);
        who = '0;
        dt  = 0;
        while (who == '0 && dt < budget) begin
            tick();
            dt++;
            who = ack;
        end
    endtask

    task automatic wait_clr_rise(input int budget, output int dt);
        dt = 0;
        while (!clr_in && dt < budget) begin
            tick();
            dt++;
        end
    endtask

    task automatic count_clr(output int n);
        n = 0;
        while (clr_in && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] who;
        int           dt;
        int           n;
        logic         stayed_zero;

        #12;
        chk("rst_ack", ack, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_clr_in", clr_in, 0);
        chk("rst_base", base_addr, 0);
        chk("rst_vidx", vec_index_out, 0);
        chk("rst_vval", vec_value_out, 0);
        rst = 1'b0;
        idle(3);

        // Single request: bits 4,1,0
        set_req(0, 64'h13);
        tick();
        chk("s_ack", ack, 4'b0001);
        chk("s_base", base_addr, 0);
        chk("s_vval", vec_value_out, mkval(0));
        chk("s_idx1", vec_index_out, 64'h13);
        req[0] = 1'b0;
        tick();
        chk("s_ack_low", ack, 0);
        chk("s_idx2", vec_index_out, 64'h03);
        chk("s_clr2", clr_out_in, 64'h10);
        tick();
        chk("s_idx3", vec_index_out, 64'h01);
        chk("s_clr3", clr_out_in, 64'h02);
        tick();
        chk("s_idx4", vec_index_out, 64'h00);
        chk("s_clr4", clr_out_in, 64'h01);
        tick();
        chk("s_clr5", clr_out_in, 64'h00);
        idle(8);

        // Round robin between 1 and 3, held continuously
        set_req(1, 64'h20);
        set_req(3, 64'h20);
        wait_ack(20, who, dt);
        chk("rr_who1", who, 4'b0010);
        chk("rr_dt1", dt, 1);
        chk("rr_idx1", vec_index_out, 64'h20);
        wait_ack(20, who, dt);
        chk("rr_who2", who, 4'b1000);
        chk("rr_dt2", dt, 3);
        chk("rr_base2", base_addr, 3);
        wait_ack(20, who, dt);
        chk("rr_who3", who, 4'b0010);
        chk("rr_dt3", dt, 4);
        wait_ack(20, who, dt);
        chk("rr_who4", who, 4'b1000);
        chk("rr_dt4", dt, 3);
        req = '0;
        idle(10);

        // Holdoff: requester 2 re-raised the cycle after ack
        set_req(2, 64'h8000_0000_0000_0001);
        wait_ack(20, who, dt);
        chk("ho_who1", who, 4'b0100);
        req[2] = 1'b0;
        tick();
        req[2] = 1'b1;
        wait_ack(20, who, dt);
        chk("ho_who2", who, 4'b0100);
        chk("ho_gap", dt + 1, 2 + 2 + 4);
        chk("ho_base", base_addr, 2);
        req = '0;
        idle(10);

        // Zero index: acked, no burst, holdoff still applies
        set_req(1, 64'h0);
        wait_ack(20, who, dt);
        chk("z_who1", who, 4'b0010);
        chk("z_base", base_addr, 1);
        chk("z_vval", vec_value_out, mkval(1));
        stayed_zero = (vec_index_out == '0);
        wait_ack(20, who, dt);
        chk("z_who2", who, 4'b0010);
        chk("z_gap", dt, 5);
        chk("z_idx0", {63'd0, stayed_zero && (vec_index_out == '0)}, 1);
        req = '0;
        idle(10);

        // Clear requested mid-burst of 8 bits; req[0] waits behind the clear
        set_req(3, 64'h0101_0101_0101_0101);
        wait_ack(20, who, dt);
        chk("c_who", who, 4'b1000);
        req[3] = 1'b0;
        idle(3);
        clr_req = 1'b1;
        set_req(0, 64'h1);
        tick();
        clr_req = 1'b0;
        n = 0;
        while (vec_index_out != '0 && n < 40) begin
            tick();
            n++;
        end
        chk("c_burst_end", n, 4);
        wait_clr_rise(40, dt);
        chk("c_drain", dt, 6);
        chk("c_busy_on", clr_busy, 1);
        chk("c_ack_held", ack, 0);
        count_clr(n);
        chk("c_len", n, 1024);
        chk("c_busy_off", clr_busy, 0);
        chk("c_ack_pre", ack, 0);
        tick();
        chk("c_ack_post", ack, 4'b0001);
        chk("c_idx_post", vec_index_out, 64'h1);
        req = '0;
        idle(10);

        // Reset at clear cycle 500, then a fresh clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("r_busy", clr_busy, 1);
        wait_clr_rise(20, dt);
        chk("r_drain", dt, 4);
        idle(499);
        chk("r_mid", clr_in, 1);
        rst = 1'b1;
        #1;
        chk("r_clr_in", clr_in, 0);
        chk("r_busy0", clr_busy, 0);
        chk("r_base0", base_addr, 0);
        chk("r_vval0", vec_value_out, 0);
        chk("r_ack0", ack, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("r_idle", clr_in, 0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wait_clr_rise(20, dt);
        chk("r2_drain", dt, 4);
        count_clr(n);
        chk("r2_len", n, 1024);
        chk("r2_busy_off", clr_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stat_update_arbiter.md
# stat_update_arbiter

Round-robin scheduler that shares one `vec_counter` statistics engine among `N_REQ` stream statistic sources. It captures one vector update per grant, feeds it bit-by-bit to the counter using the counter's `clr_out` handshake, and drives `base_addr` so each requester owns its own 64-counter region. It enforces read-modify-write spacing on the counter RAM and sequences the 1024-cycle RAM clear requested by the CPU.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 1..16; requester i maps to `base_addr = i`.
- `IDX_W`, 4: counter index bits per vector element.
- `VAL_W`, 32: value width per vector element.
- `VEC_NUM`, 16: vector elements; IW = IDX_W*VEC_NUM = 64, VW = VAL_W*VEC_NUM.
- `HOLDOFF`, 4: cycles a requester is ineligible after its burst ends.
- `DRAIN`, 4: idle cycles before clear starts.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N_REQ: level request per requester. Held with its data until `ack`.
- `req_index` in N_REQ*IW: index vector of requester i at slice [IW*(i+1)-1 : IW*i].
- `req_value` in N_REQ*VW: value vector of requester i, sliced the same way.
- `ack` out N_REQ: registered one-cycle pulse; the data has been captured.
- `clr_req` in 1: single-cycle CPU clear command.
- `clr_busy` out 1: clear pending or in progress.
- `base_addr` out 4: granted requester index, to `vec_counter.base_addr`.
- `vec_index_out` out IW: to `vec_counter.vec_index_in`.
- `vec_value_out` out VW: to `vec_counter.vec_value_in`.
- `clr_out_in` in IW: from `vec_counter.clr_out`.
- `clr_in` out 1: to `vec_counter.clr_in`.

## Operation
- States: IDLE, BURST, CLR_DRAIN, CLEAR.
- **Reset values:** state IDLE, `ack`=0, `clr_busy`=0, `clr_in`=0, `base_addr`=0. Also zero: `pend`, `vec_value_out`, holdoff counters and the round-robin pointer (points at requester 0).
- **Combinational output:** `vec_index_out = pend & ~clr_out_in`. This prevents a bit being counted twice.
- **IDLE, clear first:** a clear is pending when `clr_req` was sampled or `clr_pend` is set. If so, go to CLR_DRAIN and set `clr_busy`.
- **IDLE, grant:** otherwise, eligible = `req` with holdoff counter zero. Grant the first eligible requester at or after the pointer. At that edge:
  - `pend` <= its `req_index`;
  - `vec_value_out` <= its `req_value`;
  - `base_addr` <= i;
  - pointer <= i+1 mod N_REQ;
  - `ack[i]` = 1 next cycle;
  - go to BURST.
- **Zero index:** a granted request whose index is all zero is still acked. State stays IDLE and the holdoff is still loaded.
- **BURST, every cycle:** `pend` <= `pend & ~clr_out_in`.
  - When `vec_index_out` == 0, go to IDLE.
  - At that exit, load requester i's holdoff counter with HOLDOFF. It then decrements to 0, one per cycle.
- **`clr_req` during BURST:** sets `clr_pend`. The burst finishes first.
- **CLR_DRAIN:** DRAIN cycles with `vec_index_out` = 0, then CLEAR.
- **CLEAR:** `clr_in` = 1 for exactly 1024 consecutive cycles, so the `vec_counter` clear address pointer wraps back to 0. Then go to IDLE and clear `clr_busy` and `clr_pend`.
- **Requests during clear:** `clr_req` during CLR_DRAIN or CLEAR is ignored. Requests are not granted; they wait.
- **Requester behaviour:** a requester must deassert `req` or present new data in the cycle `ack` is high. The holdoff guarantees that it cannot be regranted from stale data.
- **Reset mid-operation:** everything returns to reset values. Partial bursts and partial clears are abandoned. `vec_counter` shares `rst`, so the clear pointers stay aligned.

## Timing
- **Grant and ack:** grant decision in cycle c, capture at the end of c, `ack` high in c+1.
- **Burst with k set bits:**
  - `vec_index_out` is nonzero in cycles c+1 .. c+k and loses its highest set bit each cycle;
  - `clr_out_in` is one-hot in cycles c+2 .. c+k+1;
  - `vec_index_out` = 0 in c+k+1; IDLE in c+k+2.
- **Back-to-back grants:** a different eligible requester can be granted in c+k+2. Minimum gap between bursts is 1 idle cycle.
- **Same requester again:** earliest regrant is c+k+2+HOLDOFF. Its first counter read then falls after the last write of its previous burst (3-cycle write latency).
- **Clear:** `clr_req` sampled in IDLE at cycle t gives `clr_busy` from t+1, `clr_in` over cycles t+1+DRAIN .. t+DRAIN+1024, and IDLE at t+DRAIN+1025.

## Test plan
- **Single request:** req[0] with index 64'h0000_0000_0000_0013 (bits 4, 1, 0). Expect `ack[0]` at c+1, `vec_index_out` sequence 13, 03, 01, 00, `base_addr` = 0, and three `clr_out_in` pulses.
- **Round-robin:** req[1] and req[3] held continuously with index bit 5. Expect grant order 1, 3, 1, 3. Each regrant of the same requester is at least HOLDOFF cycles after its burst exit.
- **Holdoff:** only req[2] asserted, re-raised the cycle after `ack`. Expect the next capture exactly HOLDOFF+1 cycles after burst exit, and no grant earlier.
- **Clear during burst:** `clr_req` in mid-burst of 8 bits. Expect the burst to complete, then 4 drain cycles, then `clr_in` high for exactly 1024 cycles. Expect `clr_busy` falling the cycle after, and a pending req[0] granted next.
- **Zero index:** req[1] with index 0. Expect `ack[1]`, no BURST, `vec_index_out` stays 0, and the holdoff is applied.
- **Reset mid-clear:** assert `rst` at clear cycle 500. Expect all outputs at reset values immediately. A new `clr_req` then gives 1024 `clr_in` cycles again.
